// File: rtl/reg_stream_loader_pkg.sv
// ============================================================================
// Module   : reg_stream_loader_pkg
// Purpose  : Shared types and widths for the register stream loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_stream_loader_pkg;

  localparam int NREG  = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_stream_loader_wr_onehot_dec.sv
// ============================================================================
// Module   : wr_onehot_dec
// Purpose  : 5-to-NOUT one-hot decoder with enable; all-zero when disabled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wr_onehot_dec
  import reg_stream_loader_pkg::*;
#(
  parameter int NOUT = 32
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [NOUT-1:0]  onehot
);

  for (genvar i = 0; i < NOUT; i++) begin : g_bit
    assign onehot[i] = en && (idx == IDX_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/reg_stream_loader.sv
// ============================================================================
// Module   : reg_stream_loader
// Purpose  : Streams a burst of words into consecutive registers (wrapping).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_stream_loader #(
  parameter int DW      = 32,
  parameter int NREG    = reg_stream_loader_pkg::NREG,
  parameter int ZERO_R0 = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [reg_stream_loader_pkg::IDX_W-1:0] base_reg,
  input  logic [reg_stream_loader_pkg::CNT_W-1:0] count,
  input  logic                                   in_valid,
  input  logic [DW-1:0]                          in_data,
  output logic                                   in_ready,
  output logic [NREG-1:0]                        reg_we,
  output logic [DW-1:0]                          reg_wdata,
  output logic                                   busy,
  output logic                                   done,
  output logic [reg_stream_loader_pkg::IDX_W-1:0] cur_reg
);

  import reg_stream_loader_pkg::*;

  state_t            r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;
  logic [NREG-1:0]   r_reg_we;
  logic [DW-1:0]     r_reg_wdata;

  logic              w_xfer;
  logic              w_we_en;
  logic [NREG-1:0]   w_we_next;

  // r_in_ready is high exactly in LOAD, so it doubles as the state qualifier
  assign w_xfer  = r_in_ready && in_valid;
  assign w_we_en = w_xfer && !((ZERO_R0 != 0) && (r_ptr == '0));

  wr_onehot_dec #(
    .NOUT(NREG)
  ) u_dec (
    .en    (w_we_en),
    .idx   (r_ptr),
    .onehot(w_we_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_reg_we    <= '0;
      r_reg_wdata <= '0;
    end else begin
      r_reg_we <= w_we_next;
      if (w_xfer) begin
        r_reg_wdata <= in_data;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (count != '0) begin
              r_ptr       <= base_reg;
              r_remaining <= count;
              r_in_ready  <= 1'b1;
              r_state     <= ST_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            r_ptr       <= r_ptr + IDX_W'(1);
            r_remaining <= r_remaining - CNT_W'(1);
            // Last word: done rises together with its registered write enable
            if (r_remaining == CNT_W'(1)) begin
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_in_ready <= 1'b0;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign reg_we    = r_reg_we;
  assign reg_wdata = r_reg_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cur_reg   = r_ptr;

endmodule

`default_nettype wire

// File: tb/tb_reg_stream_loader.sv
// ============================================================================
// Module   : tb_reg_stream_loader
// Purpose  : Directed self-checking bench for reg_stream_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  base_reg;
  logic [5:0]  count;
  logic        in_valid;
  logic [31:0] in_data;

  logic        in_ready, busy, done;
  logic [31:0] reg_we, reg_wdata;
  logic [4:0]  cur_reg;

  logic        nz_in_ready, nz_busy, nz_done;
  logic [31:0] nz_reg_we, nz_reg_wdata;
  logic [4:0]  nz_cur_reg;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  reg_stream_loader #(.DW(32), .NREG(32), .ZERO_R0(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_reg(base_reg), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .reg_we(reg_we),
    .reg_wdata(reg_wdata), .busy(busy), .done(done), .cur_reg(cur_reg)
  );

  // Same stimulus, but register 0 is writable
  reg_stream_loader #(.DW(32), .NREG(32), .ZERO_R0(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .start(start), .base_reg(base_reg), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(nz_in_ready), .reg_we(nz_reg_we),
    .reg_wdata(nz_reg_wdata), .busy(nz_busy), .done(nz_done), .cur_reg(nz_cur_reg)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] oh(input int n);
    logic [31:0] v;
    v = 32'd0;
    v[n % 32] = 1'b1;
    return v;
  endfunction

  logic [31:0] exp_we    [4];
  logic [31:0] exp_we_nz [4];
  logic        vpat      [4];

  initial begin
    rst_n = 1'b0; start = 1'b0; base_reg = '0; count = '0; in_valid = 1'b0; in_data = '0;
    step(); step();
    check_eq("rst_we",    reg_we,    0);
    check_eq("rst_wdata", reg_wdata, 0);
    check_eq("rst_ready", in_ready,  0);
    check_eq("rst_busy",  busy,      0);
    check_eq("rst_done",  done,      0);
    check_eq("rst_cur",   cur_reg,   0);
    rst_n = 1'b1;

    // Basic burst: base 3, four back-to-back words
    start = 1'b1; base_reg = 5'd3; count = 6'd4;
    step();
    check_eq("t1_ready", in_ready, 1);
    check_eq("t1_busy",  busy,     1);
    check_eq("t1_cur",   cur_reg,  3);
    check_eq("t1_we0",   reg_we,   0);
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'hA0 + 32'(i);
      step();
      check_eq($sformatf("t1_we%0d", i),    reg_we,    oh(3 + i));
      check_eq($sformatf("t1_wd%0d", i),    reg_wdata, 32'hA0 + 32'(i));
      check_eq($sformatf("t1_done%0d", i),  done,      (i == 3) ? 1 : 0);
      check_eq($sformatf("t1_ready%0d", i), in_ready,  (i == 3) ? 0 : 1);
    end
    in_valid = 1'b0;
    step();
    check_eq("t1_we_end", reg_we, 0);
    check_eq("t1_busy_end", busy, 0);
    check_eq("t1_done_end", done, 0);

    // Pointer wrap 30,31,0,1
    exp_we[0] = oh(30); exp_we[1] = oh(31); exp_we[2] = 32'd0;  exp_we[3] = oh(1);
    exp_we_nz[0] = oh(30); exp_we_nz[1] = oh(31); exp_we_nz[2] = oh(0); exp_we_nz[3] = oh(1);
    start = 1'b1; base_reg = 5'd30; count = 6'd4;
    step();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'hB0 + 32'(i);
      step();
      check_eq($sformatf("t2_we%0d", i),   reg_we,    exp_we[i]);
      check_eq($sformatf("t2_nzwe%0d", i), nz_reg_we, exp_we_nz[i]);
    end
    check_eq("t2_cur",  cur_reg, 2);
    check_eq("t2_done", done,    1);
    in_valid = 1'b0;
    step();
    check_eq("t2_busy_end", busy, 0);

    // Zero-length burst; in_valid outside LOAD must be ignored
    start = 1'b1; base_reg = 5'd7; count = 6'd0; in_valid = 1'b1;
    step();
    check_eq("t3_done",  done,     1);
    check_eq("t3_busy",  busy,     1);
    check_eq("t3_ready", in_ready, 0);
    check_eq("t3_we",    reg_we,   0);
    start = 1'b0;
    step();
    check_eq("t3_done2",  done,     0);
    check_eq("t3_busy2",  busy,     0);
    check_eq("t3_ready2", in_ready, 0);
    check_eq("t3_we2",    reg_we,   0);
    in_valid = 1'b0;

    // Stalls plus an ignored mid-burst start
    vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[3] = 1'b1;
    start = 1'b1; base_reg = 5'd8; count = 6'd2;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = vpat[i];
      in_data  = 32'hC0 + 32'(i);
      if (i == 1) begin start = 1'b1; base_reg = 5'd20; count = 6'd5; end
      if (i == 2) start = 1'b0;
      step();
      check_eq($sformatf("t4_we%0d", i), reg_we, (i == 0) ? oh(8) : (i == 3) ? oh(9) : 32'd0);
      check_eq($sformatf("t4_done%0d", i), done, (i == 3) ? 1 : 0);
    end
    check_eq("t4_wd", reg_wdata, 32'hC3);
    in_valid = 1'b0;
    step();
    check_eq("t4_busy_end", busy,    0);
    check_eq("t4_cur_end",  cur_reg, 10);

    // Asynchronous reset mid-burst
    start = 1'b1; base_reg = 5'd12; count = 6'd5;
    step();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'hD0 + 32'(i);
      step();
      check_eq($sformatf("t5_we%0d", i), reg_we, oh(12 + i));
    end
    in_data = 32'hD2;
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_we",    reg_we,    0);
    check_eq("t5_rst_wdata", reg_wdata, 0);
    check_eq("t5_rst_ready", in_ready,  0);
    check_eq("t5_rst_busy",  busy,      0);
    check_eq("t5_rst_done",  done,      0);
    check_eq("t5_rst_cur",   cur_reg,   0);
    step();
    check_eq("t5_rst_we2", reg_we, 0);
    start = 1'b1; base_reg = 5'd5; count = 6'd1;
    rst_n = 1'b1;
    step();
    check_eq("t5_new_ready", in_ready, 1);
    check_eq("t5_new_cur",   cur_reg,  5);
    check_eq("t5_new_we",    reg_we,   0);
    start = 1'b0; in_data = 32'hE0;
    step();
    check_eq("t5_new_we2",  reg_we,    oh(5));
    check_eq("t5_new_wd",   reg_wdata, 32'hE0);
    check_eq("t5_new_done", done,      1);
    in_valid = 1'b0;
    step();
    check_eq("t5_busy_end", busy, 0);

    // Full 32-word burst from register 0
    start = 1'b1; base_reg = 5'd0; count = 6'd32;
    step();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_data = 32'(i * 3 + 1);
      step();
      check_eq($sformatf("t6_nzwe%0d", i),   nz_reg_we, oh(i));
      check_eq($sformatf("t6_nzdone%0d", i), nz_done,   (i == 31) ? 1 : 0);
      if (i == 0) check_eq("t6_zr0_we0", reg_we, 0);
    end
    check_eq("t6_nzwd",  nz_reg_wdata, 32'(31 * 3 + 1));
    check_eq("t6_nzcur", nz_cur_reg,   0);
    in_valid = 1'b0;
    step();
    check_eq("t6_nzbusy_end", nz_busy,   0);
    check_eq("t6_nzwe_end",   nz_reg_we, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_stream_loader.md
REG_STREAM_LOADER -- requirements
Module: reg_stream_loader

Interface
REQ-001 SHALL have parameter DW, default 32: data word width.
REQ-002 SHALL have parameter NREG, default 32: number of target registers; the register index is 5 bits.
REQ-003 SHALL have parameter ZERO_R0, default 1: when 1, register 0 is never written.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: request a load burst; sampled only in IDLE.
REQ-007 SHALL have port base_reg, input, 5: first destination register index, latched on start.
REQ-008 SHALL have port count, input, 6: words in the burst, 0..32, latched on start.
REQ-009 SHALL have port in_valid, input, 1: the source presents in_data.
REQ-010 SHALL have port in_data, input, DW: the word to write.
REQ-011 SHALL have port in_ready, output, 1: the loader accepts a word this cycle.
REQ-012 SHALL have port reg_we, output, NREG: one-hot write enable to the register array.
REQ-013 SHALL have port reg_wdata, output, DW: write data qualified by reg_we.
REQ-014 SHALL have port busy, output, 1: a burst is in progress.
REQ-015 SHALL have port done, output, 1: one-cycle pulse marking burst completion.
REQ-016 SHALL have port cur_reg, output, 5: the next destination index (write pointer).

Function
REQ-017 SHALL implement the states IDLE, LOAD and DONE.
REQ-018 In IDLE, start=1 with count!=0 SHALL latch base_reg into the pointer and count into the remaining counter, and SHALL enter LOAD.
REQ-019 In IDLE, start=1 with count=0 SHALL enter DONE; no word is accepted.
REQ-020 in_ready SHALL be 1 only in LOAD; a word transfers on a cycle with in_valid=1 and in_ready=1.
REQ-021 For each transfer, reg_we SHALL equal the one-hot of the pointer and reg_wdata SHALL equal the word, both registered and valid exactly one cycle after the handshake.
REQ-022 reg_we SHALL be all-zero on every other cycle; reg_wdata SHALL hold its last value.
REQ-023 After each transfer, the pointer SHALL increment modulo 32 (31 wraps to 0) and the remaining counter SHALL decrement.
REQ-024 A transfer that decrements the remaining counter to 0 SHALL move the block to DONE; in_ready SHALL be 0 from the following cycle.
REQ-025 DONE SHALL last one cycle with done=1, coincident with the reg_we of the last word, then SHALL return to IDLE.
REQ-026 busy SHALL be 1 in LOAD and DONE, and 0 in IDLE.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 in_valid outside LOAD SHALL be ignored.
REQ-029 in_valid=0 in LOAD SHALL stall the burst with no timeout.
REQ-030 With ZERO_R0=1, a transfer targeting register 0 SHALL consume the word and advance the pointer, and reg_we SHALL remain all-zero for it.
REQ-031 cur_reg SHALL equal the pointer in every state.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE and set reg_we=0, reg_wdata=0, in_ready=0, busy=0, done=0, cur_reg=0 and remaining=0, including mid-burst; a pending registered write is dropped.
REQ-033 The first start SHALL be honoured on the first rising clk edge after rst_n deasserts.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE/LOAD/DONE), NREG and the 5-bit index and 6-bit count widths.
REQ-035 The design SHALL contain one sub-module, wr_onehot_dec: a 5-to-32 one-hot decoder with an enable input, driving the reg_we next-state.

Verification
REQ-036 Reset with base=3, count=4, words A..D presented back-to-back -> reg_we=bit3..bit6 on consecutive cycles, each one cycle after its handshake, done with the last write, busy=0 next cycle.
REQ-037 Wrap: base=30, count=4 -> writes to 30, 31, then register 0 suppressed (ZERO_R0=1, reg_we=0), then 1; cur_reg ends at 2.
REQ-038 count=0 -> done pulse one cycle after start, busy=1 for that cycle only, no reg_we, in_ready never 1.
REQ-039 in_valid toggles 1,0,0,1 during count=2 -> exactly two writes, no write on the stall cycles; a start issued mid-burst is ignored.
REQ-040 rst_n pulsed low after 2 of 5 words -> all outputs 0 asynchronously, no further reg_we; a new burst after reset starts from its own base_reg.
REQ-041 count=32, base=0, ZERO_R0=0 -> all 32 one-hot enables seen once in order; done after the 32nd write.
